// File: rtl/sum_accumulator_if.sv
// Handshake bundle between the nibble-adder stage, the sum accumulator and its
// downstream reader: an input sum channel and an output block-total channel.
interface sum_accumulator_if #(
    parameter int IN_W  = 4,
    parameter int ACC_W = 6
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic             out_ovf;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/sum_accumulator.sv
// Collects COUNT successive sums into an ACC_W-bit block total with a sticky
// overflow flag. Optional feature macro ACCUM_SAT_EN: clamp instead of wrap.
module sum_accumulator #(
    parameter int IN_W  = 4,
    parameter int ACC_W = 6,
    parameter int COUNT = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    sum_accumulator_if.slave bus,
    output logic             o_busy
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0] COUNT_L = 8'(COUNT);
    localparam int         PAD_W   = ACC_W + 1 - IN_W;

    state_t           r_state;
    state_t           w_state_n;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_acc_n;
    logic [7:0]       r_cnt;
    logic [7:0]       w_cnt_n;
    logic             r_ovf;
    logic             w_ovf_n;
    logic [ACC_W:0]   w_sum;
    logic             w_accept;

    assign w_accept = bus.in_valid && (r_state != DONE);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_acc   <= w_acc_n;
            r_cnt   <= w_cnt_n;
            r_ovf   <= w_ovf_n;
        end
    end

    // The extra sum bit is the carry out of the accumulator and flags overflow.
    always_comb begin
        w_state_n = r_state;
        w_acc_n   = r_acc;
        w_cnt_n   = r_cnt;
        w_ovf_n   = r_ovf;
        w_sum     = ((r_state == ACCUM) ? {1'b0, r_acc} : '0)
                  + {{PAD_W{1'b0}}, bus.in_data};

        case (r_state)
            IDLE, ACCUM: begin
                if (w_accept) begin
                    w_cnt_n = (r_state == IDLE) ? 8'd1 : (r_cnt + 8'd1);
                    w_ovf_n = r_ovf | w_sum[ACC_W];
`ifdef ACCUM_SAT_EN
                    w_acc_n = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
`else
                    w_acc_n = w_sum[ACC_W-1:0];
`endif
                    w_state_n = (w_cnt_n == COUNT_L) ? DONE : ACCUM;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_state_n = IDLE;
                    w_acc_n   = '0;
                    w_cnt_n   = '0;
                    w_ovf_n   = 1'b0;
                end
            end
            default: begin
                w_state_n = IDLE;
                w_acc_n   = '0;
                w_cnt_n   = '0;
                w_ovf_n   = 1'b0;
            end
        endcase
    end

    // Total and flag are gated so the output bus reads zero between blocks.
    assign bus.in_ready  = (r_state != DONE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.out_data  = (r_state == DONE) ? r_acc : '0;
    assign bus.out_ovf   = (r_state == DONE) ? r_ovf : 1'b0;
    assign o_busy        = (r_state == ACCUM);
endmodule

// File: tb/tb_sum_accumulator.sv
// Bench for sum_accumulator: a COUNT=8 and a COUNT=1 instance checked every
// cycle against a block-total model, plus directed literal scenarios.
module tb_sum_accumulator;
    localparam int IN_W  = 4;
    localparam int ACC_W = 6;
    localparam int MAXV  = (1 << ACC_W) - 1;

    logic clk = 1'b0;
    logic rst;
    logic busy0;
    logic busy1;

    always #5 clk = ~clk;

    sum_accumulator_if #(.IN_W(IN_W), .ACC_W(ACC_W)) bus0 ();
    sum_accumulator_if #(.IN_W(IN_W), .ACC_W(ACC_W)) bus1 ();

    sum_accumulator #(.IN_W(IN_W), .ACC_W(ACC_W), .COUNT(8)) dut0 (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus0),
        .o_busy  (busy0)
    );

    sum_accumulator #(.IN_W(IN_W), .ACC_W(ACC_W), .COUNT(1)) dut1 (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus1),
        .o_busy  (busy1)
    );

    int nChecks = 0;
    int nPass   = 0;

    // Model: per instance, how many sums are in the block, their plain total,
    // and whether the total is waiting to be read.
    int mN[2];
    int mTotal[2];
    bit mDone[2];
    int limit[2] = '{8, 1};
    int pop0[$];
    int ovf0[$];
    int pop1[$];
    int ovf1[$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int expData(input int total);
`ifdef ACCUM_SAT_EN
        return (total > MAXV) ? MAXV : total;
`else
        return total % (MAXV + 1);
`endif
    endfunction

    task automatic modelCycle(input int k, input logic inReady, input logic outValid,
                              input logic [31:0] outData, input logic outOvf, input logic busy,
                              input logic inValid, input int inData, input logic outReady);
        checkOutput($sformatf("in_ready%0d", k),  {31'd0, inReady},  {31'd0, !mDone[k]});
        checkOutput($sformatf("out_valid%0d", k), {31'd0, outValid}, {31'd0, mDone[k]});
        checkOutput($sformatf("busy%0d", k),      {31'd0, busy},     {31'd0, (mN[k] > 0) && !mDone[k]});
        checkOutput($sformatf("out_data%0d", k),  outData,           mDone[k] ? expData(mTotal[k]) : 0);
        checkOutput($sformatf("out_ovf%0d", k),   {31'd0, outOvf},   {31'd0, mDone[k] && (mTotal[k] > MAXV)});
        if (rst) begin
            mN[k] = 0; mTotal[k] = 0; mDone[k] = 0;
        end else if (mDone[k]) begin
            if (outReady) begin
                if (k == 0) begin pop0.push_back(int'(outData)); ovf0.push_back(int'(outOvf)); end
                else        begin pop1.push_back(int'(outData)); ovf1.push_back(int'(outOvf)); end
                mN[k] = 0; mTotal[k] = 0; mDone[k] = 0;
            end
        end else if (inValid) begin
            mTotal[k] += inData;
            mN[k]++;
            if (mN[k] == limit[k]) mDone[k] = 1;
        end
    endtask

    // Outputs are compared on the falling edge; inputs change just after the rising edge.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            modelCycle(0, bus0.in_ready, bus0.out_valid, 32'(bus0.out_data), bus0.out_ovf, busy0,
                       bus0.in_valid, int'(bus0.in_data), bus0.out_ready);
            modelCycle(1, bus1.in_ready, bus1.out_valid, 32'(bus1.out_data), bus1.out_ovf, busy1,
                       bus1.in_valid, int'(bus1.in_data), bus1.out_ready);
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input int k, input logic v, input logic [3:0] d, input logic r);
        if (k == 0) begin
            bus0.in_valid = v; bus0.in_data = d; bus0.out_ready = r;
        end else begin
            bus1.in_valid = v; bus1.in_data = d; bus1.out_ready = r;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkPop0(input string name, input int idx, input int data, input int ovf);
        checkOutput({name, " pops"}, 32'(pop0.size() > idx), 32'd1);
        if (pop0.size() > idx) begin
            checkOutput({name, " data"}, 32'(pop0[idx]), 32'(data));
            checkOutput({name, " ovf"},  32'(ovf0[idx]), 32'(ovf));
        end
    endtask

    initial begin
        rst = 1'b1;
        bus0.in_valid = 0; bus0.in_data = 0; bus0.out_ready = 1;
        bus1.in_valid = 0; bus1.in_data = 0; bus1.out_ready = 1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("reset in_ready",  {31'd0, bus0.in_ready},  32'd1);
        checkOutput("reset out_valid", {31'd0, bus0.out_valid}, 32'd0);
        checkOutput("reset out_data",  32'(bus0.out_data),      32'd0);
        checkOutput("reset out_ovf",   {31'd0, bus0.out_ovf},   32'd0);
        checkOutput("reset busy",      {31'd0, busy0},          32'd0);

        $display("[TB] sequence 1..8");
        pop0.delete(); ovf0.delete();
        for (int i = 1; i <= 8; i++) applyStimulus(0, 1, 4'(i), 1);
        checkOutput("seq valid", {31'd0, bus0.out_valid}, 32'd1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("seq valid after pop", {31'd0, bus0.out_valid}, 32'd0);
        checkOutput("seq busy after pop",  {31'd0, busy0},          32'd0);
        checkPop0("seq", 0, 36, 0);

        $display("[TB] eight sums of 15");
        pop0.delete(); ovf0.delete();
        for (int i = 0; i < 8; i++) applyStimulus(0, 1, 4'd15, 1);
        applyStimulus(0, 0, 0, 1);
`ifdef ACCUM_SAT_EN
        checkPop0("fifteen", 0, 63, 1);
`else
        checkPop0("fifteen", 0, 56, 1);
`endif

        $display("[TB] backpressure");
        pop0.delete(); ovf0.delete();
        for (int i = 1; i <= 8; i++) applyStimulus(0, 1, 4'(i), 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 4'd9, 0);
            checkOutput("stall in_ready", {31'd0, bus0.in_ready}, 32'd0);
            checkOutput("stall out_data", 32'(bus0.out_data),     32'd36);
        end
        applyStimulus(0, 1, 4'd9, 1);
        checkOutput("after pop in_ready", {31'd0, bus0.in_ready}, 32'd1);
        checkOutput("after pop busy",     {31'd0, busy0},         32'd0);
        for (int i = 0; i < 8; i++) applyStimulus(0, 1, 4'd1, 1);
        applyStimulus(0, 0, 0, 1);
        checkPop0("stall first", 0, 36, 0);
        checkPop0("stall next",  1, 8, 0);

        $display("[TB] reset mid-block");
        pop0.delete(); ovf0.delete();
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 4'd5, 1);
        rst = 1'b1;
        applyStimulus(0, 0, 0, 1);
        rst = 1'b0;
        checkOutput("post reset busy",     {31'd0, busy0},         32'd0);
        checkOutput("post reset in_ready", {31'd0, bus0.in_ready}, 32'd1);
        for (int i = 0; i < 8; i++) applyStimulus(0, 1, 4'd1, 1);
        applyStimulus(0, 0, 0, 1);
        checkPop0("mid reset", 0, 8, 0);
        checkOutput("mid reset pop count", 32'(pop0.size()), 32'd1);

        $display("[TB] COUNT=1 instance");
        pop1.delete(); ovf1.delete();
        applyStimulus(1, 1, 4'd7, 1);
        checkOutput("c1 bubble1 in_ready", {31'd0, bus1.in_ready}, 32'd0);
        checkOutput("c1 first total",      32'(bus1.out_data),     32'd7);
        applyStimulus(1, 1, 4'd9, 1);
        checkOutput("c1 after pop in_ready", {31'd0, bus1.in_ready}, 32'd1);
        applyStimulus(1, 1, 4'd9, 1);
        checkOutput("c1 bubble2 in_ready", {31'd0, bus1.in_ready}, 32'd0);
        checkOutput("c1 second total",     32'(bus1.out_data),     32'd9);
        applyStimulus(1, 0, 0, 1);
        checkOutput("c1 pop count", 32'(pop1.size()), 32'd2);
        if (pop1.size() == 2) begin
            checkOutput("c1 pop0", 32'(pop1[0]), 32'd7);
            checkOutput("c1 pop1", 32'(pop1[1]), 32'd9);
        end

        $display("[TB] random traffic");
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            bus0.in_valid  = ($urandom_range(0, 3) != 0);
            bus0.in_data   = 4'($urandom_range(0, 15));
            bus0.out_ready = ($urandom_range(0, 2) != 0);
            bus1.in_valid  = $urandom_range(0, 1) == 1;
            bus1.in_data   = 4'($urandom_range(0, 15));
            bus1.out_ready = $urandom_range(0, 1) == 1;
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        applyStimulus(0, 0, 0, 1);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule

// File: doc/sum_accumulator.md
# sum_accumulator

Downstream consumer of the registered 4-bit nibble-adder result. Collects a fixed number of successive sums over a valid/ready handshake, accumulates them into a wider total, and presents the block total with its own valid/ready handshake and an overflow flag. Sits between the adder stage and the output pins or readout logic.

## Interface

Parameters:
- IN_W, default 4: width of each incoming sum; matches the adder result width.
- ACC_W, default 6: accumulator and total width; must be at least IN_W.
- COUNT, default 8: sums per block; legal range 1..255.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset, sampled on rising clk.
- in_valid  input  1  upstream has a sum on in_data.
- in_ready  output  1  block can accept a sum this cycle.
- in_data  input  IN_W  unsigned sum from the adder stage.
- out_valid  output  1  block total available on out_data.
- out_ready  input  1  downstream accepts the total this cycle.
- out_data  output  ACC_W  unsigned block total.
- out_ovf  output  1  at least one addition in this block exceeded 2^ACC_W−1.
- busy  output  1  high when at least one sum of the current block has been accepted and the total is not yet presented.

## Operation

- State machine with states IDLE, ACCUM and DONE. The state is registered. cnt is 8 bits. acc is ACC_W bits. ovf is sticky.
- Accept event: in_valid & in_ready on a rising edge.
- in_ready = (state != DONE). It is combinational from the state only and does not depend on in_valid.
- IDLE:
  - acc=0, cnt=0, ovf=0.
  - On accept: acc ← zero-extended in_data; cnt ← 1.
  - Next state is DONE if COUNT=1, otherwise ACCUM.
- ACCUM:
  - On accept: acc ← acc + zero-extended in_data; cnt ← cnt+1.
  - If the new cnt equals COUNT, next state is DONE.
  - No accept: hold all state.
- DONE:
  - out_valid=1; out_data=acc; out_ovf=ovf; in_valid is ignored.
  - On out_valid & out_ready: go to IDLE and clear acc, cnt and ovf on the same edge.
- Arithmetic:
  - Compute the sum at ACC_W+1 bits.
  - Overflow means bit ACC_W of that sum is 1. Overflow sets ovf, which stays set until the block is popped or reset.
  - Without saturation, the result wraps modulo 2^ACC_W (see Configuration).
- busy = (state == ACCUM) | (state == IDLE is false and state != DONE). Equivalently, busy is high exactly in ACCUM.
- Reset at any point, including mid-block or while DONE is stalled:
  - Next state is IDLE; acc, cnt and ovf are 0.
  - A partial block or an unread total is discarded.
- out_data and out_ovf are 0 whenever out_valid=0.

## Timing

- Reset values: in_ready=1, out_valid=0, out_data=0, out_ovf=0, busy=0.
- Latency: out_valid rises on the clock edge that accepts the COUNT-th sum, so it is visible in the next cycle.
- Throughput:
  - One sum per cycle while in IDLE or ACCUM.
  - One bubble cycle per block in DONE, with the minimum when out_ready=1.
  - Best case is COUNT+1 cycles per block.
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_ovf and out_valid hold stable and in_ready stays 0.
- in_ready returns to 1 in the cycle after the pop edge. A simultaneous pop and input does not accept the input.
- Simultaneous reset with any handshake: reset wins and nothing is accepted or popped.

## Configuration

- Macro ACCUM_SAT_EN.
- Defined: on overflow, acc clamps to 2^ACC_W−1 and further additions keep it there. ovf is set.
- Undefined (default): acc wraps modulo 2^ACC_W. ovf is set identically.

## Test plan

- Reset, then feed 1,2,3,4,5,6,7,8 back-to-back with out_ready=1:
  - out_valid is high for 1 cycle after the 8th accept.
  - out_data=36, out_ovf=0, busy=0 afterwards.
- Feed eight sums of 15:
  - Without ACCUM_SAT_EN: out_data=56 (120 mod 64), out_ovf=1.
  - With ACCUM_SAT_EN: out_data=63, out_ovf=1.
- Complete a block totalling 36 and hold out_ready=0 for 3 cycles while in_valid=1 with in_data=9:
  - in_ready=0, and out_data stays 36 throughout.
  - On the pop, nothing is accepted. The next block starts from 0.
- Accept 3 sums of 5, assert reset for 1 cycle, then feed eight sums of 1:
  - out_data=8, out_ovf=0; busy is 0 in the cycle after reset.
- With COUNT=1, feed 7 then 9 while out_ready=1:
  - Two totals, 7 then 9, each followed by a one-cycle in_ready=0 bubble.
